// File: rtl/shift_sub_divider_if.sv
// Request/result bundle for the shift-subtract divider.
interface shift_sub_divider_if #(
    parameter int unsigned WIDTH = 24
);
    logic                   Start;
    logic [2*WIDTH-1:0]     Dividend;
    logic [WIDTH-1:0]       Divisor;
    logic                   Busy;
    logic                   Done;
    logic [WIDTH-1:0]       Quotient;
    logic [WIDTH-1:0]       Remainder;
    logic                   Ovf;
    logic                   DivZero;

    modport master (
        output Start, Dividend, Divisor,
        input  Busy, Done, Quotient, Remainder, Ovf, DivZero
    );

    modport slave (
        input  Start, Dividend, Divisor,
        output Busy, Done, Quotient, Remainder, Ovf, DivZero
    );
endinterface

// File: rtl/shift_sub_divider.sv
// Unsigned 2W/W restoring shift-subtract divider, one quotient bit per clock.
// Optional SSD_FAST_EXIT_EN: overflow/divide-by-zero requests skip the RUN phase.
module shift_sub_divider #(
    parameter int unsigned WIDTH = 24
) (
    input  logic               clk,
    input  logic               rst,
    shift_sub_divider_if.slave bus
);
    localparam int unsigned CW = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state, state_next;
    logic [WIDTH-1:0]  r, r_next;
    logic [WIDTH-1:0]  q, q_next;
    logic [WIDTH-1:0]  d, d_next;
    logic [CW-1:0]     cnt, cnt_next;
    logic              err_ovf, err_ovf_next;
    logic              err_dz, err_dz_next;
    logic [WIDTH-1:0]  quo_next, rem_next;
    logic              ovf_next, dz_next;

    logic [WIDTH:0]    t;
    logic [WIDTH-1:0]  diff;
    logic              ge;
    logic [WIDTH-1:0]  hi;
    logic              dz_in, ovf_in;

    // Partial remainder stays below the divisor, so its extra top bit is always 0 and is not stored.
    always_comb begin
        state_next   = state;
        r_next       = r;
        q_next       = q;
        d_next       = d;
        cnt_next     = cnt;
        err_ovf_next = err_ovf;
        err_dz_next  = err_dz;
        quo_next     = bus.Quotient;
        rem_next     = bus.Remainder;
        ovf_next     = bus.Ovf;
        dz_next      = bus.DivZero;

        t      = {r, q[WIDTH-1]};
        ge     = (t >= {1'b0, d});
        diff   = t[WIDTH-1:0] - d;
        hi     = bus.Dividend[2*WIDTH-1:WIDTH];
        dz_in  = (bus.Divisor == '0);
        ovf_in = !dz_in && (hi >= bus.Divisor);

        case (state)
            IDLE: begin
                if (bus.Start) begin
                    r_next       = hi;
                    q_next       = bus.Dividend[WIDTH-1:0];
                    d_next       = bus.Divisor;
                    cnt_next     = CW'(WIDTH - 1);
                    err_ovf_next = ovf_in;
                    err_dz_next  = dz_in;
                    ovf_next     = 1'b0;
                    dz_next      = 1'b0;
                    state_next   = RUN;
`ifdef SSD_FAST_EXIT_EN
                    if (ovf_in || dz_in) begin
                        state_next = DONE;
                        quo_next   = '1;
                        rem_next   = '0;
                        ovf_next   = ovf_in;
                        dz_next    = dz_in;
                    end
`endif
                end
            end
            RUN: begin
                r_next   = ge ? diff : t[WIDTH-1:0];
                q_next   = {q[WIDTH-2:0], ge};
                cnt_next = cnt - CW'(1);
                if (cnt == '0) begin
                    state_next = DONE;
                    if (err_ovf || err_dz) begin
                        quo_next = '1;
                        rem_next = '0;
                    end else begin
                        quo_next = q_next;
                        rem_next = r_next;
                    end
                    ovf_next = err_ovf;
                    dz_next  = err_dz;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, datapath and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            r             <= '0;
            q             <= '0;
            d             <= '0;
            cnt           <= '0;
            err_ovf       <= 1'b0;
            err_dz        <= 1'b0;
            bus.Busy      <= 1'b0;
            bus.Done      <= 1'b0;
            bus.Quotient  <= '0;
            bus.Remainder <= '0;
            bus.Ovf       <= 1'b0;
            bus.DivZero   <= 1'b0;
        end else begin
            state         <= state_next;
            r             <= r_next;
            q             <= q_next;
            d             <= d_next;
            cnt           <= cnt_next;
            err_ovf       <= err_ovf_next;
            err_dz        <= err_dz_next;
            bus.Busy      <= (state_next != IDLE);
            bus.Done      <= (state_next == DONE);
            bus.Quotient  <= quo_next;
            bus.Remainder <= rem_next;
            bus.Ovf       <= ovf_next;
            bus.DivZero   <= dz_next;
        end
    end
endmodule

// File: tb/tb_shift_sub_divider.sv
// Bench for shift_sub_divider: arithmetic reference model with per-cycle output checks.
module tb_shift_sub_divider;
`ifdef SSD_FAST_EXIT_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        int          k;
        int          kd;
        logic [23:0] q;
        logic [23:0] r;
        logic        ovf;
        logic        dz;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   tests = 0;
    int   errs = 0;

    exp_t        expq[$];
    logic [23:0] last_q, last_r;
    logic        last_ovf, last_dz;

    shift_sub_divider_if #(.WIDTH(24)) bus ();

    shift_sub_divider #(.WIDTH(24)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        tests++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Reference: plain integer division, error if divisor is 0 or quotient exceeds 24 bits.
    function automatic exp_t model(input logic [47:0] a, input logic [23:0] b, input int k);
        exp_t e;
        e.k = k; e.ovf = 1'b0; e.dz = 1'b0;
        if (b == 24'd0) begin
            e.dz = 1'b1; e.q = 24'hFFFFFF; e.r = 24'd0;
        end else if ((a / 48'(b)) > 48'hFFFFFF) begin
            e.ovf = 1'b1; e.q = 24'hFFFFFF; e.r = 24'd0;
        end else begin
            e.q = 24'(a / 48'(b));
            e.r = 24'(a % 48'(b));
        end
        e.kd = ((e.ovf || e.dz) && FAST) ? k : k + 24;
        return e;
    endfunction

    // Per-cycle compare of every output against the model's expected timeline.
    always @(negedge clk) begin
        logic exp_busy, exp_done;
        if (!rst) begin
            exp_busy = 1'b0;
            exp_done = 1'b0;
            if (expq.size() > 0) begin
                exp_busy = (cyc >= expq[0].k) && (cyc <= expq[0].kd);
                exp_done = (cyc == expq[0].kd);
                if (cyc == expq[0].k) begin
                    last_ovf = 1'b0;
                    last_dz  = 1'b0;
                end
                if (exp_done) begin
                    last_q   = expq[0].q;
                    last_r   = expq[0].r;
                    last_ovf = expq[0].ovf;
                    last_dz  = expq[0].dz;
                    void'(expq.pop_front());
                end
            end
            chk("busy", 48'(bus.Busy), 48'(exp_busy));
            chk("done", 48'(bus.Done), 48'(exp_done));
            chk("quotient", 48'(bus.Quotient), 48'(last_q));
            chk("remainder", 48'(bus.Remainder), 48'(last_r));
            chk("ovf", 48'(bus.Ovf), 48'(last_ovf));
            chk("divzero", 48'(bus.DivZero), 48'(last_dz));
        end
    end

    task automatic start_op(input logic [47:0] a, input logic [23:0] b);
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = a; bus.Divisor = b;
        @(posedge clk);
        #1;
        bus.Start = 1'b0;
        expq.push_back(model(a, b, cyc));
    endtask

    task automatic wait_done(input string name, input logic [23:0] eq, input logic [23:0] er,
                             input logic eo, input logic ez);
        bit got = 1'b0;
        for (int i = 0; i < 40 && !got; i++) begin
            @(negedge clk);
            if (bus.Done) got = 1'b1;
        end
        if (!got) begin
            tests++; errs++;
            $display("FAIL %s: no Done within 40 cycles", name);
        end else begin
            chk({name, "_q"}, 48'(bus.Quotient), 48'(eq));
            chk({name, "_r"}, 48'(bus.Remainder), 48'(er));
            chk({name, "_ovf"}, 48'(bus.Ovf), 48'(eo));
            chk({name, "_dz"}, 48'(bus.DivZero), 48'(ez));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [23:0] ra, rb;
        int          k0;
        rst = 1'b1;
        bus.Start = 1'b0; bus.Dividend = '0; bus.Divisor = '0;
        last_q = '0; last_r = '0; last_ovf = 1'b0; last_dz = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 48'(bus.Busy), 48'd0);
        chk("rst_done", 48'(bus.Done), 48'd0);
        chk("rst_q", 48'(bus.Quotient), 48'd0);
        chk("rst_r", 48'(bus.Remainder), 48'd0);
        chk("rst_ovf", 48'(bus.Ovf), 48'd0);
        chk("rst_dz", 48'(bus.DivZero), 48'd0);
        #1 rst = 1'b0;

        start_op(48'd1000, 24'd7);
        wait_done("d1000_7", 24'd142, 24'd6, 1'b0, 1'b0);
        start_op(48'hFFFFFE000001, 24'hFFFFFF);
        wait_done("maxfit", 24'hFFFFFF, 24'd0, 1'b0, 1'b0);
        start_op(48'h000001000000, 24'd1);
        wait_done("ovf", 24'hFFFFFF, 24'd0, 1'b1, 1'b0);
        start_op(48'd12345, 24'd0);
        wait_done("divzero", 24'hFFFFFF, 24'd0, 1'b0, 1'b1);
        start_op(48'h000000FFFFFF, 24'h000100);
        wait_done("d_ffffff_100", 24'h00FFFF, 24'h0000FF, 1'b0, 1'b0);

        // Start re-pulsed mid-run with different operands must be ignored.
        start_op(48'd1000, 24'd7);
        repeat (5) @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = 48'd99; bus.Divisor = 24'd2;
        @(negedge clk);
        bus.Start = 1'b0;
        wait_done("ignored_start", 24'd142, 24'd6, 1'b0, 1'b0);

        // Asynchronous reset in the middle of RUN discards the operation.
        start_op(48'd1000, 24'd7);
        repeat (10) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_busy", 48'(bus.Busy), 48'd0);
        chk("arst_done", 48'(bus.Done), 48'd0);
        chk("arst_q", 48'(bus.Quotient), 48'd0);
        chk("arst_r", 48'(bus.Remainder), 48'd0);
        chk("arst_ovf", 48'(bus.Ovf), 48'd0);
        chk("arst_dz", 48'(bus.DivZero), 48'd0);
        expq.delete();
        last_q = '0; last_r = '0; last_ovf = 1'b0; last_dz = 1'b0;
        repeat (2) @(negedge clk);
        #1 rst = 1'b0;
        repeat (30) @(negedge clk);
        start_op(48'd50, 24'd5);
        wait_done("after_rst", 24'd10, 24'd0, 1'b0, 1'b0);

        // Start held high re-triggers 26 cycles after the first acceptance.
        @(negedge clk);
        bus.Start = 1'b1; bus.Dividend = 48'd50; bus.Divisor = 24'd5;
        @(posedge clk);
        #1;
        k0 = cyc;
        expq.push_back(model(48'd50, 24'd5, k0));
        expq.push_back(model(48'd50, 24'd5, k0 + 26));
        wait_done("hold1", 24'd10, 24'd0, 1'b0, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1 bus.Start = 1'b0;
        wait_done("hold2", 24'd10, 24'd0, 1'b0, 1'b0);

        // Round trip: (A*B)/B recovers A exactly.
        for (int i = 0; i < 6; i++) begin
            ra = 24'($urandom_range(0, 32'h00FFFFFF));
            rb = 24'($urandom_range(1, 32'h00FFFFFF));
            start_op(48'(ra) * 48'(rb), rb);
            wait_done("roundtrip", ra, 24'd0, 1'b0, 1'b0);
        end

        repeat (5) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, errs);
        $finish;
    end
endmodule
